// File: rtl/sprite_mover.sv
// sprite_mover: per-frame bouncing sprite position generator, X then Y updated one cycle apart.
// Define SPRITE_MOVER_WRAP_EN to wrap around the visible area instead of bouncing.
module sprite_mover #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int SPRITE_W  = 32,
  parameter int SPRITE_H  = 32,
  parameter int INIT_X    = 0,
  parameter int INIT_Y    = 0,
  parameter int STEP_X    = 2,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       pause,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       bounce_x,
  output logic       bounce_y,
  output logic       busy
);
  localparam logic [10:0] XMAX = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] YMAX = 11'(SCREEN_H - SPRITE_H);
  localparam logic [10:0] SX = 11'(STEP_X);
  localparam logic [10:0] SY = 11'(STEP_Y);
  localparam logic [15:0] DIV_LAST = 16'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y} state_t;
  state_t state;
  logic vsync_q, tick;
  logic [15:0] div_cnt;
  logic [11:0] nx, ny;

  // Returns {next position, next direction, edge event}; compares widened to 11 bits.
  function automatic logic [11:0] axis(input logic [9:0] p, input logic d, input logic [10:0] s,
                                       input logic [10:0] m);
    logic [10:0] q;
    q = {1'b0, p};
`ifdef SPRITE_MOVER_WRAP_EN
    if (d) return (q + s > m) ? {10'd0, d, 1'b1} : {p + s[9:0], d, 1'b0};
    return (q < s) ? {m[9:0], d, 1'b1} : {p - s[9:0], d, 1'b0};
`else
    if (d) return (q + s >= m) ? {m[9:0], 1'b0, 1'b1} : {p + s[9:0], d, 1'b0};
    return (q <= s) ? {10'd0, 1'b1, 1'b1} : {p - s[9:0], d, 1'b0};
`endif
  endfunction

  assign tick = vsync_q & ~vsync;
  assign nx = axis(sprite_x, dir_x, SX, XMAX);
  assign ny = axis(sprite_y, dir_y, SY, YMAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      vsync_q  <= 1'b1;
      div_cnt  <= '0;
      sprite_x <= 10'(INIT_X);
      sprite_y <= 10'(INIT_Y);
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      busy     <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      case (state)
        IDLE: if (tick && !pause) begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= MOVE_X;
            busy    <= 1'b1;
          end else div_cnt <= div_cnt + 16'd1;
        end
        MOVE_X: begin
          {sprite_x, dir_x, bounce_x} <= nx;
          state <= MOVE_Y;
        end
        MOVE_Y: begin
          {sprite_y, dir_y, bounce_y} <= ny;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: four parameterisations driven by shared vsync/pause, checked against a frame-level model.
module tb_sprite_mover;
`ifdef SPRITE_MOVER_WRAP_EN
  localparam int X1 = 607;
`else
  localparam int X1 = 606;
`endif
  localparam int SW[4]  = '{640, 640, 640, 40};
  localparam int SH[4]  = '{480, 480, 480, 40};
  localparam int IX[4]  = '{0, X1, 0, 2};
  localparam int IY[4]  = '{0, 447, 0, 7};
  localparam int STY[4] = '{1, 1, 1, 3};
  localparam int FD[4]  = '{1, 1, 3, 1};

  logic clk = 0, reset, vsync, pause;
  logic [9:0] sx[4], sy[4];
  logic dx[4], dy[4], bx[4], by[4], bz[4];
  int vectors = 0, errors = 0, n = 0;
  bit armed = 0, mvq = 1;
  int mx[4], my[4], mdx[4], mdy[4], mbx[4], mby[4], div[4], acc[4];
  int px[4], pdx[4], pbx[4], py[4], pdy[4], pby[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sprite_mover #(.SCREEN_W(SW[g]), .SCREEN_H(SH[g]), .INIT_X(IX[g]), .INIT_Y(IY[g]),
                   .STEP_Y(STY[g]), .FRAME_DIV(FD[g])) u (
      .clk(clk), .reset(reset), .vsync(vsync), .pause(pause),
      .sprite_x(sx[g]), .sprite_y(sy[g]), .dir_x(dx[g]), .dir_y(dy[g]),
      .bounce_x(bx[g]), .bounce_y(by[g]), .busy(bz[g]));
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One move along an axis: signed step, then clamp-and-reverse or wrap at the edges.
  task automatic step(input int p, input int d, input int s, input int m,
                      output int np, output int nd, output int nb);
    np = d ? p + s : p - s;
    nd = d;
    nb = 0;
`ifdef SPRITE_MOVER_WRAP_EN
    if (np > m) begin np = 0; nb = 1; end
    else if (np < 0) begin np = m; nb = 1; end
`else
    if (d && np >= m) begin np = m; nd = 0; nb = 1; end
    else if (!d && np <= 0) begin np = 0; nd = 1; nb = 1; end
`endif
  endtask

  // Model: an accepted frame at cycle a shows X at a+1, Y at a+2, busy during a..a+1.
  always @(posedge clk) begin
    n++;
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        mx[i] = IX[i]; my[i] = IY[i]; mdx[i] = 1; mdy[i] = 1;
        mbx[i] = 0; mby[i] = 0; div[i] = 0; acc[i] = -10;
      end else begin
        mbx[i] = 0; mby[i] = 0;
        if (n == acc[i] + 1) begin mx[i] = px[i]; mdx[i] = pdx[i]; mbx[i] = pbx[i]; end
        if (n == acc[i] + 2) begin my[i] = py[i]; mdy[i] = pdy[i]; mby[i] = pby[i]; end
        if (mvq && !vsync && !pause && n >= acc[i] + 3) begin
          if (div[i] == FD[i] - 1) begin
            div[i] = 0;
            acc[i] = n;
            step(mx[i], mdx[i], 2, SW[i] - 32, px[i], pdx[i], pbx[i]);
            step(my[i], mdy[i], STY[i], SH[i] - 32, py[i], pdy[i], pby[i]);
          end else div[i]++;
        end
      end
    end
    mvq = reset ? 1'b1 : vsync;
  end

  always @(posedge clk) begin
    #1;
    if (armed)
      for (int i = 0; i < 4; i++)
        chk($sformatf("cyc%0d dut%0d {x,y,dx,dy,bx,by,busy}", n, i),
            int'({sx[i], sy[i], dx[i], dy[i], bx[i], by[i], bz[i]}),
            int'({10'(mx[i]), 10'(my[i]), mdx[i][0], mdy[i][0], mbx[i][0], mby[i][0],
                  (n == acc[i] || n == acc[i] + 1)}));
  end

  task automatic frame(input bit p);
    @(negedge clk);
    pause = p;
    vsync = 0;
    @(negedge clk);
    vsync = 1;
    pause = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1; vsync = 1; pause = 0;
    repeat (3) @(negedge clk);
    armed = 1;
    reset = 0;
    repeat (10) @(negedge clk);
    chk("reset x", sx[0], 0); chk("reset y", sy[0], 0);
    chk("reset dir_x", dx[0], 1); chk("reset dir_y", dy[0], 1);
    chk("reset busy", bz[0], 0); chk("reset bounce", bx[0] | by[0], 0);
    vsync = 0;
    @(negedge clk);
    vsync = 1;
    chk("E busy", bz[0], 1); chk("E x unchanged", sx[0], 0);
    @(negedge clk);
    chk("E+1 x", sx[0], 2); chk("E+1 busy", bz[0], 1); chk("E+1 y unchanged", sy[0], 0);
    chk("div3 no update", sx[2], 0); chk("div3 idle", bz[2], 0);
    chk("edge x bounce", bx[1], 1);
`ifdef SPRITE_MOVER_WRAP_EN
    chk("wrap x", sx[1], 0); chk("wrap dir_x", dx[1], 1);
`else
    chk("edge x", sx[1], 608); chk("edge dir_x", dx[1], 0);
`endif
    @(negedge clk);
    chk("E+2 y", sy[0], 1); chk("E+2 busy", bz[0], 0); chk("bounce_x one cycle", bx[1], 0);
`ifndef SPRITE_MOVER_WRAP_EN
    chk("edge y", sy[1], 448); chk("edge y bounce", by[1], 1); chk("edge dir_y", dy[1], 0);
`endif
    repeat (3) @(negedge clk);
    frame(1);
    repeat (4) frame(0);
    chk("6 ticks x", sx[0], 10); chk("6 ticks y", sy[0], 5);
    chk("div3 x", sx[2], 2); chk("div3 y", sy[2], 1);
`ifndef SPRITE_MOVER_WRAP_EN
    chk("reverse x", sx[1], 600); chk("reverse y", sy[1], 444);
    chk("small x", sx[3], 4); chk("small dir_x", dx[3], 0);
    chk("small y", sy[3], 3); chk("small dir_y", dy[3], 1);
`endif
    @(negedge clk); vsync = 0;
    @(negedge clk); vsync = 1;
    @(negedge clk); vsync = 0;
    @(negedge clk); vsync = 1;
    repeat (4) @(negedge clk);
    chk("busy tick ignored x", sx[0], 12); chk("busy tick ignored y", sy[0], 6);
    chk("div3 second x", sx[2], 4); chk("div3 second y", sy[2], 2);
    repeat (4) frame(0);
    @(negedge clk); vsync = 0;
    @(negedge clk); vsync = 1; reset = 1;
    @(negedge clk); reset = 0;
    chk("mid reset x", sx[0], 0); chk("mid reset busy", bz[0], 0);
    chk("mid reset dut1 x", sx[1], X1); chk("mid reset dir_x", dx[3], 1);
    @(negedge clk);
    chk("mid reset y held", sy[0], 0); chk("mid reset dut1 y", sy[1], 447);
    frame(0);
    chk("post reset x", sx[0], 2); chk("post reset y", sy[0], 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
